// File: rtl/seq_gen_pkg.sv
// Shared definitions for the repeating serial pattern generator.
package seq_gen_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned GAP_DEF = 2;
  localparam logic        IDLE_LVL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Effective bit count: 0 behaves as 1, anything above w is clamped to w.
  function automatic int unsigned eff_len(input logic [3:0] len, input int unsigned w);
    int unsigned l;
    l = 32'(len);
    if (l == 0) l = 1;
    if (l > w) l = w;
    return l;
  endfunction

endpackage

// File: rtl/seq_gen_piso.sv
// Parallel-load, MSB-first shift register holding the bits still to be sent.
module piso_shift #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= q << 1;
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends an L-bit pattern MSB-first R times with GAP idle cycles between.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned GAP = GAP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] pattern,
  input  logic [3:0]   len,
  input  logic [3:0]   reps,
  output logic         x_out,
  output logic         x_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned LW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);

  state_t        state_q, state_d;
  logic          x_out_d, x_valid_d, busy_d, done_d;
  logic [LW-1:0] bit_cnt_q, bit_cnt_d;
  logic [LW-1:0] lm1_q, lm1_d;
  logic [3:0]    rep_cnt_q, rep_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]  pat_q, pat_d;

  logic          sh_load, sh_shift, sh_msb;
  logic [W-1:0]  sh_din;
  logic          restart;
  int unsigned   in_len;
  logic [W-1:0]  in_pat;

  piso_shift #(.W(W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  // Pattern left-aligned so pattern[L-1] sits at the MSB.
  always_comb begin
    in_len = eff_len(len, W);
    in_pat = pattern << (W - in_len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_out     <= IDLE_LVL;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt_q <= '0;
      lm1_q     <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_out     <= x_out_d;
      x_valid   <= x_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      bit_cnt_q <= bit_cnt_d;
      lm1_q     <= lm1_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
    end
  end

  // Next-state and next-output logic; outputs describe the cycle after the edge.
  always_comb begin
    state_d   = state_q;
    x_out_d   = IDLE_LVL;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    lm1_d     = lm1_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pat_q << 1;
    restart   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d     = in_pat;
          lm1_d     = LW'(in_len - 1);
          bit_cnt_d = LW'(in_len - 1);
          rep_cnt_d = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
          sh_load   = 1'b1;
          sh_din    = in_pat << 1;
          x_out_d   = in_pat[W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q != '0) begin
          sh_shift  = 1'b1;
          x_out_d   = sh_msb;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = bit_cnt_q - LW'(1);
        end else if (rep_cnt_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (GAP == 0) begin
          restart = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LAST;
          busy_d    = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
          busy_d    = 1'b1;
        end else begin
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Begin the next repetition from the captured copy.
    if (restart) begin
      state_d   = S_SHIFT;
      sh_load   = 1'b1;
      sh_din    = pat_q << 1;
      x_out_d   = pat_q[W-1];
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
      bit_cnt_d = lm1_q;
      rep_cnt_d = rep_cnt_q - 4'd1;
    end
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter W, default 8, sets the maximum pattern width in bits.
REQ-002 Parameter GAP, default 2, sets the number of idle cycles between repetitions.
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port start, input, 1 bit, SHALL request a transmission; sampled only when busy=0.
REQ-006 Port abort, input, 1 bit, SHALL be a synchronous cancel of any transmission in progress.
REQ-007 Port pattern, input, W bits, SHALL carry the bits to send; captured on accepted start.
REQ-008 Port len, input, 4 bits, SHALL give the bit count per repetition; captured on accepted start.
REQ-009 Port reps, input, 4 bits, SHALL give the repetition count; captured on accepted start.
REQ-010 Port x_out, output, 1 bit, SHALL be the registered serial data line.
REQ-011 Port x_valid, output, 1 bit, SHALL be high exactly in cycles where x_out carries a pattern bit.
REQ-012 Port busy, output, 1 bit, SHALL be high from the first bit through the final bit.
REQ-013 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-015 IDLE with start=1 and abort=0 SHALL capture pattern/len/reps and enter SHIFT; the first bit SHALL appear on x_out the following cycle.
REQ-016 Bits SHALL go MSB-first within the effective length: pattern[L-1] down to pattern[0], one bit per cycle, x_valid=1.
REQ-017 Effective length L: len=0 SHALL be treated as 1; len>W SHALL be clamped to W.
REQ-018 Effective repetitions R: reps=0 SHALL be treated as 1; otherwise R=reps (max 15).
REQ-019 After the last bit of a repetition, if repetitions remain, the block SHALL enter GAP for exactly GAP cycles, then re-send the captured pattern; GAP=0 SHALL give back-to-back repetitions.
REQ-020 After the last bit of the last repetition, the block SHALL return to IDLE with done=1 and busy=0 for one cycle.
REQ-021 A start in the done cycle SHALL be accepted; first new bit SHALL appear the next cycle.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 Changes on pattern/len/reps after capture SHALL NOT affect the transmission in progress.
REQ-024 abort=1 in SHIFT or GAP SHALL force IDLE next cycle: x_out=1, x_valid=0, busy=0, and no done pulse.
REQ-025 abort and start together in IDLE: abort SHALL win, and start SHALL be ignored.
REQ-026 Outside SHIFT (IDLE and GAP), x_out SHALL be 1 and x_valid SHALL be 0.
REQ-027 Total busy cycles SHALL equal R*L + (R-1)*GAP.

Reset
REQ-028 reset=1 SHALL immediately force: state IDLE, x_out=1, x_valid=0, busy=0, done=0, and all counters/shift register cleared.
REQ-029 reset mid-transmission SHALL discard the transmission; no done pulse SHALL follow reset release.

Structure
REQ-030 Package seq_gen_pkg SHALL hold the state encoding (IDLE/SHIFT/GAP), the idle line level (1), and the W/GAP defaults.
REQ-031 A sub-module piso_shift (W-bit parallel-load, MSB-out shift register with load/shift enables) SHALL hold the pattern; bit, gap and repetition counters stay in seq_gen.

Verification
REQ-032 W=8, pattern=8'h01, len=4, reps=1, start one cycle -> x_out 0,0,0,1 with x_valid=1 on cycles 1-4, done=1 on cycle 5.
REQ-033 pattern=8'h01, len=3, reps=3, GAP=2 -> 0,0,1,[1,1 idle],0,0,1,[1,1],0,0,1; busy 13 cycles; done on cycle 14.
REQ-034 Bench SHALL cover start held during busy and start pulsed in the done cycle -> no restart mid-transfer, then immediate back-to-back transfer, with pattern changed after capture having no effect.
REQ-035 abort during bit 2 of len=4 -> IDLE next cycle, x_out=1, x_valid=0, and no done pulse ever.
REQ-036 reset asserted mid-SHIFT -> outputs at reset values in the same cycle; after release, IDLE with no done pulse.
REQ-037 len=0 -> single bit pattern[0]; len=12 with W=8 -> 8 bits; reps=0 -> one repetition.
